// File: rtl/peak_tracker_pkg.sv
// -----------------------------------------------------------------------------
// peak_tracker_pkg
// Shared definitions for the stream peak tracker:
//   DATA_W  - width of an input sample (3-bit unsigned)
//   state_t - frame FSM states IDLE / ACCUM / OUT
//   strict_win() - fully decoded "this side won" from a gt/lt/eq triple
// -----------------------------------------------------------------------------
package peak_tracker_pkg;

    localparam int DATA_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    // True only when the winning flag is set and both other flags are clear,
    // so an inconsistent compare result never causes an update.
    function automatic logic strict_win(input logic win, input logic lose, input logic tie);
        return win & ~lose & ~tie;
    endfunction

endpackage

// File: rtl/peak_cmp.sv
// -----------------------------------------------------------------------------
// peak_cmp
// Combinational unsigned magnitude compare of two samples.
// Ports:
//   a, b  in  DATA_W  operands
//   gt    out 1       a > b
//   lt    out 1       a < b
//   eq    out 1       a == b
// -----------------------------------------------------------------------------
module peak_cmp
    import peak_tracker_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/stream_peak_tracker.sv
// -----------------------------------------------------------------------------
// stream_peak_tracker
// Accumulates per-frame statistics over a valid/ready sample stream and
// presents one result per frame on a valid/ready output.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   input handshake; in_data (3-bit sample), in_last (frame end)
//   out_valid/ready  output handshake
//   out_max/out_min  largest / smallest sample of the frame
//   out_count        samples in the frame (saturating at 2^CNT_W-1)
//   out_rise         samples strictly above their predecessor (saturating)
// Build option: define PEAK_TRACKER_MIN_EN to include min tracking; without it
// the min logic is absent and out_min is tied to 0.
// -----------------------------------------------------------------------------
module stream_peak_tracker
    import peak_tracker_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_count,
    output logic [CNT_W-1:0]  out_rise
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  rise_q, rise_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic [CNT_W-1:0]  out_rise_q, out_rise_d;

    logic accept_s;
    logic max_gt_s, max_lt_s, max_eq_s;
    logic prev_gt_s, prev_lt_s, prev_eq_s;
    logic max_up_s, prev_up_s;

    // in_ready_q is registered, so acceptance never depends on out_ready.
    assign accept_s  = in_valid & in_ready_q;

    peak_cmp u_cmp_max (
        .a  (in_data),
        .b  (max_q),
        .gt (max_gt_s),
        .lt (max_lt_s),
        .eq (max_eq_s)
    );

    peak_cmp u_cmp_prev (
        .a  (in_data),
        .b  (prev_q),
        .gt (prev_gt_s),
        .lt (prev_lt_s),
        .eq (prev_eq_s)
    );

    assign max_up_s  = strict_win(max_gt_s, max_lt_s, max_eq_s);
    assign prev_up_s = strict_win(prev_gt_s, prev_lt_s, prev_eq_s);

`ifdef PEAK_TRACKER_MIN_EN
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] out_min_q, out_min_d;
    logic              min_gt_s, min_lt_s, min_eq_s;
    logic              min_up_s;

    peak_cmp u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .gt (min_gt_s),
        .lt (min_lt_s),
        .eq (min_eq_s)
    );

    assign min_up_s = strict_win(min_lt_s, min_gt_s, min_eq_s);
    assign out_min  = out_min_q;
`else
    assign out_min  = {DATA_W{1'b0}};
`endif

    // Next-state, accumulator and output-register computation.
    always_comb begin
        state_d     = state_q;
        max_d       = max_q;
        prev_d      = prev_q;
        count_d     = count_q;
        rise_d      = rise_q;
        out_max_d   = out_max_q;
        out_count_d = out_count_q;
        out_rise_d  = out_rise_q;
`ifdef PEAK_TRACKER_MIN_EN
        min_d       = min_q;
        out_min_d   = out_min_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    max_d   = in_data;
                    prev_d  = in_data;
                    count_d = CNT_ONE;
                    rise_d  = CNT_ZERO;
`ifdef PEAK_TRACKER_MIN_EN
                    min_d   = in_data;
`endif
                    if (in_last) begin
                        state_d = OUT;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    if (max_up_s) begin
                        max_d = in_data;
                    end else begin
                        max_d = max_q;
                    end
`ifdef PEAK_TRACKER_MIN_EN
                    if (min_up_s) begin
                        min_d = in_data;
                    end else begin
                        min_d = min_q;
                    end
`endif
                    prev_d = in_data;
                    // Counters stop at all-ones instead of wrapping.
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                    if (prev_up_s && (rise_q != CNT_MAX)) begin
                        rise_d = rise_q + CNT_ONE;
                    end else begin
                        rise_d = rise_q;
                    end
                    if (in_last) begin
                        state_d = OUT;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture the result as the frame closes, including the last sample.
        if ((state_q != OUT) && (state_d == OUT)) begin
            out_max_d   = max_d;
            out_count_d = count_d;
            out_rise_d  = rise_d;
`ifdef PEAK_TRACKER_MIN_EN
            out_min_d   = min_d;
`endif
        end else begin
            out_max_d   = out_max_q;
            out_count_d = out_count_q;
            out_rise_d  = out_rise_q;
`ifdef PEAK_TRACKER_MIN_EN
            out_min_d   = out_min_q;
`endif
        end

        out_valid_d = (state_d == OUT);
        in_ready_d  = (state_d != OUT);
    end

    // State, accumulator and registered-output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            max_q       <= {DATA_W{1'b0}};
            prev_q      <= {DATA_W{1'b0}};
            count_q     <= CNT_ZERO;
            rise_q      <= CNT_ZERO;
            out_max_q   <= {DATA_W{1'b0}};
            out_count_q <= CNT_ZERO;
            out_rise_q  <= CNT_ZERO;
`ifdef PEAK_TRACKER_MIN_EN
            min_q       <= {DATA_W{1'b0}};
            out_min_q   <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            max_q       <= max_d;
            prev_q      <= prev_d;
            count_q     <= count_d;
            rise_q      <= rise_d;
            out_max_q   <= out_max_d;
            out_count_q <= out_count_d;
            out_rise_q  <= out_rise_d;
`ifdef PEAK_TRACKER_MIN_EN
            min_q       <= min_d;
            out_min_q   <= out_min_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_count = out_count_q;
    assign out_rise  = out_rise_q;

endmodule

// File: tb/tb_stream_peak_tracker.sv
// -----------------------------------------------------------------------------
// tb_stream_peak_tracker
// Drives one shared sample stream into two trackers (CNT_W=8 and CNT_W=2) and
// compares every presented result against frame statistics computed directly
// from the list of samples sent.
// -----------------------------------------------------------------------------
module tb_stream_peak_tracker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       rdy8, vld8;
    logic [2:0] max8, min8;
    logic [7:0] cnt8, rise8;
    logic       rdy2, vld2;
    logic [2:0] max2, min2;
    logic [1:0] cnt2, rise2;

    int n_cmp;
    int n_err;
    int frame_q[$];

    stream_peak_tracker #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data), .in_last(in_last),
        .out_valid(vld8), .out_ready(out_ready),
        .out_max(max8), .out_min(min8), .out_count(cnt8), .out_rise(rise8)
    );

    stream_peak_tracker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data), .in_last(in_last),
        .out_valid(vld2), .out_ready(out_ready),
        .out_max(max2), .out_min(min2), .out_count(cnt2), .out_rise(rise2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame statistics straight from the sample list, saturating at cap.
    task automatic frame_stats(input int cap, output int emax, output int emin,
                               output int ecnt, output int erise);
        int rises;
        emax  = frame_q[0];
        emin  = frame_q[0];
        rises = 0;
        foreach (frame_q[i]) begin
            if (frame_q[i] > emax) emax = frame_q[i];
            if (frame_q[i] < emin) emin = frame_q[i];
            if (i > 0 && frame_q[i] > frame_q[i-1]) rises++;
        end
        ecnt  = (frame_q.size() > cap) ? cap : frame_q.size();
        erise = (rises > cap) ? cap : rises;
`ifndef PEAK_TRACKER_MIN_EN
        emin = 0;
`endif
    endtask

    task automatic check_outputs(input string tag);
        int emax, emin, ecnt, erise;
        frame_stats(255, emax, emin, ecnt, erise);
        check_eq({tag, "_max8"},  max8,  emax);
        check_eq({tag, "_min8"},  min8,  emin);
        check_eq({tag, "_cnt8"},  cnt8,  ecnt);
        check_eq({tag, "_rise8"}, rise8, erise);
        frame_stats(3, emax, emin, ecnt, erise);
        check_eq({tag, "_max2"},  max2,  emax);
        check_eq({tag, "_min2"},  min2,  emin);
        check_eq({tag, "_cnt2"},  cnt2,  ecnt);
        check_eq({tag, "_rise2"}, rise2, erise);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_vld"},  {vld8, vld2}, 0);
        check_eq({tag, "_rdy"},  {rdy8, rdy2}, 0);
        check_eq({tag, "_max"},  {max8, max2}, 0);
        check_eq({tag, "_min"},  {min8, min2}, 0);
        check_eq({tag, "_cnt"},  {cnt8, cnt2}, 0);
        check_eq({tag, "_rise"}, {rise8, rise2}, 0);
    endtask

    // Offer one sample and wait (bounded) for it to be taken.
    task automatic send_sample(input int d, input bit last);
        int guard;
        in_valid = 1'b1;
        in_data  = d[2:0];
        in_last  = last;
        guard    = 0;
        while (!rdy8 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            check_eq("ready_timeout", 0, 1);
        end else begin
            check_eq("rdy2_match", rdy2, 1);
            @(posedge clk); #1;
            frame_q.push_back(d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send a full frame from vals, optionally with stalls, then check and drain.
    task automatic run_frame(input string tag, input int vals[$], input bit stall, input int hold);
        frame_q.delete();
        foreach (vals[i]) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            send_sample(vals[i], (i == vals.size() - 1));
        end
        check_eq({tag, "_vld"}, {vld8, vld2}, 3);
        check_outputs(tag);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_vld"}, {vld8, vld2}, 3);
            check_eq({tag, "_hold_rdy"}, {rdy8, rdy2}, 0);
            check_outputs({tag, "_hold"});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_post_vld"}, {vld8, vld2}, 0);
        check_eq({tag, "_post_rdy"}, {rdy8, rdy2}, 3);
        check_outputs({tag, "_post"});
    endtask

    initial begin
        int vals[$];
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 3'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_rdy", {rdy8, rdy2}, 3);

        vals = '{3, 5, 5, 1, 6};
        run_frame("basic", vals, 1'b0, 10);

        vals = '{4};
        run_frame("single", vals, 1'b0, 0);

        vals = '{0, 1, 2, 3, 3};
        run_frame("sat2", vals, 1'b1, 1);

        vals = '{7, 2};
        run_frame("min_opt", vals, 1'b0, 2);

        for (int f = 0; f < 25; f++) begin
            vals.delete();
            repeat ($urandom_range(1, 8)) vals.push_back(int'($urandom_range(0, 7)));
            run_frame("rand", vals, 1'b1, $urandom_range(0, 3));
        end

        vals.delete();
        for (int i = 0; i < 520; i++) vals.push_back((i % 2 == 0) ? 0 : 7);
        run_frame("sat8", vals, 1'b0, 1);

        // Abort a frame part-way with an asynchronous reset.
        frame_q.delete();
        send_sample(2, 1'b0);
        send_sample(7, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        vals = '{1};
        run_frame("after_rst", vals, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_peak_tracker.md
STREAM_PEAK_TRACKER -- requirements
Module: stream_peak_tracker

Interface
REQ-001 Parameter CNT_W, default 8: width of the sample and rise counters, legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  in_data and in_last are valid this cycle.
REQ-005 in_ready  output  1  block accepts a sample this cycle; a sample transfers when in_valid and in_ready are both high.
REQ-006 in_data  input  3  unsigned sample.
REQ-007 in_last  input  1  the accepted sample closes the current frame.
REQ-008 out_valid  output  1  frame result is presented.
REQ-009 out_ready  input  1  consumer takes the result; the result transfers when out_valid and out_ready are both high.
REQ-010 out_max  output  3  largest sample in the frame.
REQ-011 out_min  output  3  smallest sample in the frame; see REQ-026.
REQ-012 out_count  output  CNT_W  number of samples in the frame, saturating.
REQ-013 out_rise  output  CNT_W  number of samples strictly greater than their predecessor in the same frame, saturating.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCUM and OUT.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM and 0 in OUT, decoded only from the registered state, with no combinational path from out_ready.
REQ-016 In IDLE, an accepted sample SHALL load max=min=prev=in_data, count=1 and rise=0; next state is OUT if in_last is 1, else ACCUM.
REQ-017 In ACCUM, on each accepted sample:
  - max updates if in_data > max;
  - min updates if in_data < min;
  - rise increments if in_data > prev;
  - prev is set to in_data;
  - count increments.
REQ-018 Equal values SHALL update neither max, min nor rise.
REQ-019 count and rise SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 Accepting a sample with in_last=1 SHALL move the FSM to OUT; out_valid rises on the following cycle, carrying that sample's updates.
REQ-021 In OUT, out_valid SHALL be 1 and out_max, out_min, out_count and out_rise SHALL be registered and held stable until the handshake.
REQ-022 The OUT handshake SHALL return the FSM to IDLE; out_valid is 0 on the next cycle, which gives exactly one cycle between frames.
REQ-023 With in_valid=0, state and accumulators SHALL hold; stalls of any length inside a frame are legal.
REQ-024 Outside OUT, out_valid SHALL be 0 and the data outputs SHALL hold their last presented values.

Reset
REQ-025 While rst is 1:
  - state = IDLE;
  - out_valid = 0, in_ready = 0;
  - out_max, out_min, out_count, out_rise and all internal accumulators = 0.
  A partial frame in progress is discarded, and no result is emitted for it.

Configuration
REQ-026 Macro PEAK_TRACKER_MIN_EN:
  - defined: min tracking is present and out_min behaves per REQ-016/017;
  - undefined: min logic is omitted and out_min is constant 0.
  All other behaviour is identical in both builds.

Structure
REQ-027 Package peak_tracker_pkg SHALL hold the state enum (IDLE, ACCUM, OUT) and the constant DATA_W=3.
REQ-028 Sub-module peak_cmp SHALL be a combinational 3-bit unsigned magnitude compare with outputs gt, lt and eq; it is instantiated three times (vs max, vs min, vs prev).

Verification
REQ-029 Frame 3,5,5,1,6(last), out_ready=1 -> one result: max=6, min=1, count=5, rise=2.
REQ-030 Single-sample frame 4(last) -> out_valid on the next cycle: max=4, min=4, count=1, rise=0.
REQ-031 CNT_W=2, frame of 5 ascending-repeat samples 0,1,2,3,3(last) -> count=3 (saturated), rise=3.
REQ-032 out_ready held 0 for 10 cycles in OUT -> outputs stable, in_ready=0; release -> IDLE and in_ready=1 the next cycle.
REQ-033 rst asserted asynchronously mid-frame after 2,7 -> immediate zeros; new frame 1(last) -> max=1, min=1, count=1.
REQ-034 Build without PEAK_TRACKER_MIN_EN, frame 7,2(last) -> out_min=0, max=7, count=2.
